// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART command path: controller state encoding,
// command opcodes, default framing/response bytes and the packet checksum.
// The SYNC/ACK/NAK defaults are meant to be reused by TX-side blocks.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CSUM,
    ST_EXEC,
    ST_TX_ACK,
    ST_TX_DATA,
    ST_TX_NAK
  } state_e;

  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_READ      = 8'h02;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

  // Packet checksum; reads pass data as zero.
  function automatic logic [7:0] calcCsum(input logic [7:0] cmd,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

  function automatic logic isValidCmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer
// Turns a held byte request into exactly one tx_start pulse under the
// transmitter start/busy handshake, and reports completion of the request in
// the same cycle as the pulse.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   req_i       level request: a byte is waiting to be sent
//   byte_i      byte to send while req_i is high
//   tx_busy_i   transmitter busy
//   tx_start_o  one-cycle start strobe to the transmitter
//   tx_data_o   byte to transmit, held until the next start
//   done_o      the requested byte was handed over this cycle
// ---------------------------------------------------------------------------
module uart_tx_sequencer
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       done_o
);

  logic       startPrev_q;
  logic [7:0] data_q;

  // A start is only issued when the transmitter is free and no start was
  // issued the cycle before; the busy flag of the transmitter only rises the
  // cycle after a start, so the previous-start guard prevents back-to-back
  // pulses during that gap.
  assign tx_start_o = req_i & ~tx_busy_i & ~startPrev_q;
  assign done_o     = tx_start_o;

  // The new byte must be visible in the same cycle as its start pulse.
  assign tx_data_o  = tx_start_o ? byte_i : data_q;

  // Remember the last start and hold the last transmitted byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      startPrev_q <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      startPrev_q <= tx_start_o;
      if (tx_start_o) begin
        data_q <= byte_i;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_controller.sv
// ---------------------------------------------------------------------------
// uart_cmd_controller
// Parses SYNC/CMD/ADDR/[DATA]/CSUM packets from the UART receiver, performs
// a one-cycle register write or read, and answers with ACK (+ read data) or
// NAK through the transmitter start/busy handshake. Keeps a saturating count
// of rejected, timed-out and overrun packets.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   rx_data_ready, rx_data    received byte strobe and value
//   reg_wr_en, reg_rd_en      one-cycle register access strobes
//   reg_addr, reg_wdata       register address / write data
//   reg_rdata                 read data, valid the cycle after reg_rd_en
//   tx_start, tx_data         transmitter start strobe and byte
//   tx_busy                   transmitter busy
//   err_count                 saturating error counter
//   busy                      controller not idle
// ---------------------------------------------------------------------------
module uart_cmd_controller
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         rdata_q;
  logic               rdCapture_q;
  logic [CNT_W-1:0]   timeoutCnt_q, timeoutCnt_d;
  logic [7:0]         errCount_q;
  logic               errInc;
  logic               inGet;
  logic               txReq;
  logic [7:0]         txByte;
  logic               txDone;

  assign inGet = (state_q == ST_GET_CMD)  || (state_q == ST_GET_ADDR) ||
                 (state_q == ST_GET_DATA) || (state_q == ST_GET_CSUM);

  // Next-state, field capture, timeout and error-event logic.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    data_d       = data_q;
    timeoutCnt_d = '0;
    errInc       = 1'b0;
    txReq        = 1'b0;
    txByte       = ACK_BYTE;

    case (state_q)
      ST_IDLE: begin
        if (rx_data_ready && (rx_data == SYNC_BYTE)) begin
          state_d = ST_GET_CMD;
          // Clearing data makes the checksum of a read use data = 0.
          data_d  = 8'h00;
        end
      end
      ST_GET_CMD: begin
        if (rx_data_ready) begin
          cmd_d   = rx_data;
          state_d = ST_GET_ADDR;
        end
      end
      ST_GET_ADDR: begin
        if (rx_data_ready) begin
          addr_d  = rx_data;
          // Only writes carry a data byte; invalid commands skip it too.
          state_d = (cmd_q == CMD_WRITE) ? ST_GET_DATA : ST_GET_CSUM;
        end
      end
      ST_GET_DATA: begin
        if (rx_data_ready) begin
          data_d  = rx_data;
          state_d = ST_GET_CSUM;
        end
      end
      ST_GET_CSUM: begin
        if (rx_data_ready) begin
          if (isValidCmd(cmd_q) && (rx_data == calcCsum(cmd_q, addr_q, data_q))) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_TX_NAK;
            errInc  = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_TX_ACK;
      end
      ST_TX_ACK: begin
        txReq  = 1'b1;
        txByte = ACK_BYTE;
        if (txDone) begin
          state_d = (cmd_q == CMD_READ) ? ST_TX_DATA : ST_IDLE;
        end
      end
      ST_TX_DATA: begin
        txReq  = 1'b1;
        txByte = rdata_q;
        if (txDone) begin
          state_d = ST_IDLE;
        end
      end
      ST_TX_NAK: begin
        txReq  = 1'b1;
        txByte = NAK_BYTE;
        if (txDone) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte timeout: an accepted byte leaves the counter at zero.
    if (inGet && !rx_data_ready) begin
      if (timeoutCnt_q == TIMEOUT_LAST) begin
        state_d = ST_IDLE;
        errInc  = 1'b1;
      end else begin
        timeoutCnt_d = timeoutCnt_q + 1'b1;
      end
    end

    // A byte arriving while executing or responding is dropped and counted.
    if (rx_data_ready && !inGet && (state_q != ST_IDLE)) begin
      errInc = 1'b1;
    end
  end

  // State and packet-field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 8'h00;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      timeoutCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      timeoutCnt_q <= timeoutCnt_d;
    end
  end

  // Read data is valid the cycle after the read strobe, so capture is
  // delayed by one cycle through rdCapture_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdCapture_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      rdCapture_q <= reg_rd_en;
      if (rdCapture_q) begin
        rdata_q <= reg_rdata;
      end
    end
  end

  // Saturating error counter; simultaneous events count once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount_q <= 8'h00;
    end else if (errInc && (errCount_q != 8'hFF)) begin
      errCount_q <= errCount_q + 8'h01;
    end
  end

  uart_tx_sequencer u_txSeq (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (txReq),
    .byte_i     (txByte),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .done_o     (txDone)
  );

  assign reg_wr_en = (state_q == ST_EXEC) && (cmd_q == CMD_WRITE);
  assign reg_rd_en = (state_q == ST_EXEC) && (cmd_q == CMD_READ);
  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;
  assign err_count = errCount_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_controller.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_controller
// Drives packets into uart_cmd_controller, models the transmitter busy flag
// and the register read-data timing, and compares what comes out against
// expectations computed from the packet rules.
// ---------------------------------------------------------------------------
module tb_uart_cmd_controller;

  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] err_count;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int errExp = 0;
  int cycleCnt = 0;
  int lastRxCycle = -10;
  int latencyErr = 0;
  int startBusyErr = 0;
  int startDoubleErr = 0;
  bit prevStart = 1'b0;
  bit rdSeen = 1'b0;
  bit startSeen = 1'b0;
  int busyLeft = 0;
  logic [7:0] rdVal = 8'h5A;

  logic [7:0] wrAddrQ[$];
  logic [7:0] wrDataQ[$];
  logic [7:0] rdAddrQ[$];
  logic [7:0] txQ[$];

  always #5 clk = ~clk;

  uart_cmd_controller #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .reg_wr_en     (reg_wr_en),
    .reg_rd_en     (reg_rd_en),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .err_count     (err_count),
    .busy          (busy)
  );

  // Cycle counter used for latency measurement.
  always @(posedge clk) cycleCnt++;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_data_ready) lastRxCycle = cycleCnt;
    if (reg_wr_en) begin
      wrAddrQ.push_back(reg_addr);
      wrDataQ.push_back(reg_wdata);
      if (cycleCnt != lastRxCycle + 1) latencyErr++;
    end
    if (reg_rd_en) begin
      rdAddrQ.push_back(reg_addr);
      rdSeen = 1'b1;
      if (cycleCnt != lastRxCycle + 1) latencyErr++;
    end
    if (tx_start) begin
      txQ.push_back(tx_data);
      startSeen = 1'b1;
      if (tx_busy) startBusyErr++;
      if (prevStart) startDoubleErr++;
    end
    prevStart = tx_start;
  end

  // Register bank read data: valid only in the cycle after reg_rd_en.
  always @(posedge clk) begin
    #1;
    if (rdSeen) begin
      reg_rdata = rdVal;
      rdSeen = 1'b0;
    end else begin
      reg_rdata = ~rdVal;
    end
  end

  // Transmitter model: busy from the cycle after tx_start for a random time.
  always @(posedge clk) begin
    #1;
    if (startSeen) begin
      tx_busy = 1'b1;
      busyLeft = $urandom_range(1, 5);
      startSeen = 1'b0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) tx_busy = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(posedge clk);
    #2;
    rx_data = b;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #2;
    rx_data_ready = 1'b0;
    repeat (gap) waitCycle();
  endtask

  task automatic clearQueues();
    wrAddrQ.delete();
    wrDataQ.delete();
    rdAddrQ.delete();
    txQ.delete();
    latencyErr = 0;
    startBusyErr = 0;
    startDoubleErr = 0;
  endtask

  function automatic int satInc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic runPacket(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] csum,
                           input logic [7:0] rdv, input int nJunk,
                           input bit ovr, input int gapMax, input string tag);
    logic [7:0] junk;
    logic [7:0] expTx[$];
    logic [7:0] csumRef;
    bit isWr, isRd, valid;
    int n;
    clearQueues();
    rdVal = rdv;
    junk = 8'h11;
    for (int i = 0; i < nJunk; i++) begin
      applyStimulus(junk, $urandom_range(0, gapMax));
      junk = junk + 8'h11;
    end
    applyStimulus(8'hA5, $urandom_range(0, gapMax));
    applyStimulus(cmd, $urandom_range(0, gapMax));
    applyStimulus(addr, $urandom_range(0, gapMax));
    if (cmd == 8'h01) applyStimulus(data, $urandom_range(0, gapMax));
    applyStimulus(csum, ovr ? 0 : $urandom_range(0, gapMax));
    if (ovr) applyStimulus(8'h77, 0);
    n = 0;
    while ((busy || tx_busy) && n < 300) begin
      waitCycle();
      n++;
    end
    checkOutput({tag, ".idleWait"}, int'(n < 300), 1);
    waitCycle();

    // Reference: packet rules applied directly to the bytes sent.
    isWr = (cmd == 8'h01);
    isRd = (cmd == 8'h02);
    csumRef = cmd ^ addr ^ (isWr ? data : 8'h00);
    valid = (isWr || isRd) && (csum == csumRef);
    if (valid) begin
      expTx.push_back(8'h06);
      if (isRd) expTx.push_back(rdv);
    end else begin
      expTx.push_back(8'h15);
      errExp = satInc(errExp);
    end
    if (ovr) errExp = satInc(errExp);

    checkOutput({tag, ".wrCount"}, wrAddrQ.size(), (valid && isWr) ? 1 : 0);
    checkOutput({tag, ".rdCount"}, rdAddrQ.size(), (valid && isRd) ? 1 : 0);
    if (valid && isWr) begin
      checkOutput({tag, ".wrAddr"}, (wrAddrQ.size() > 0) ? int'(wrAddrQ[0]) : -1, int'(addr));
      checkOutput({tag, ".wrData"}, (wrDataQ.size() > 0) ? int'(wrDataQ[0]) : -1, int'(data));
    end
    if (valid && isRd) begin
      checkOutput({tag, ".rdAddr"}, (rdAddrQ.size() > 0) ? int'(rdAddrQ[0]) : -1, int'(addr));
    end
    checkOutput({tag, ".txCount"}, txQ.size(), expTx.size());
    for (int i = 0; i < expTx.size(); i++) begin
      checkOutput($sformatf("%s.txByte%0d", tag, i),
                  (i < txQ.size()) ? int'(txQ[i]) : -1, int'(expTx[i]));
    end
    checkOutput({tag, ".errCount"}, int'(err_count), errExp);
    checkOutput({tag, ".latency"}, latencyErr, 0);
    checkOutput({tag, ".startWhileBusy"}, startBusyErr, 0);
    checkOutput({tag, ".startTwice"}, startDoubleErr, 0);
    checkOutput({tag, ".busyEnd"}, int'(busy), 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] a, d, c, cs, rv;
    int kind;
    rst_n = 1'b0;
    rx_data_ready = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    reg_rdata = 8'h00;
    repeat (3) waitCycle();

    $display("[TB] reset values");
    checkOutput("rst.strobes", int'({reg_wr_en, reg_rd_en, tx_start, busy}), 0);
    checkOutput("rst.regAddr", int'(reg_addr), 0);
    checkOutput("rst.regWdata", int'(reg_wdata), 0);
    checkOutput("rst.txData", int'(tx_data), 0);
    checkOutput("rst.errCount", int'(err_count), 0);
    rst_n = 1'b1;
    repeat (2) waitCycle();

    $display("[TB] directed packets");
    runPacket(8'h01, 8'h10, 8'h3C, 8'h2D, 8'h5A, 0, 1'b0, 2, "write");
    runPacket(8'h02, 8'h20, 8'h00, 8'h22, 8'h5A, 0, 1'b0, 2, "read");
    runPacket(8'h01, 8'h10, 8'h3C, 8'h00, 8'h5A, 0, 1'b0, 2, "badCsum");

    $display("[TB] inter-byte timeout");
    clearQueues();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    repeat (TIMEOUT - 1) waitCycle();
    checkOutput("timeout.busyBefore", int'(busy), 1);
    waitCycle();
    checkOutput("timeout.busyAfter", int'(busy), 0);
    errExp = satInc(errExp);
    repeat (8) waitCycle();
    checkOutput("timeout.errCount", int'(err_count), errExp);
    checkOutput("timeout.txCount", txQ.size(), 0);
    checkOutput("timeout.wrCount", wrAddrQ.size(), 0);
    runPacket(8'h01, 8'h33, 8'hC4, 8'h01 ^ 8'h33 ^ 8'hC4, 8'h5A, 0, 1'b0, 2, "afterTimeout");

    $display("[TB] leading junk bytes");
    runPacket(8'h02, 8'h20, 8'h00, 8'h22, 8'h5A, 2, 1'b0, 2, "junkRead");

    $display("[TB] random packets");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      rv = 8'($urandom_range(0, 255));
      case (kind)
        0: begin c = 8'h01; cs = c ^ a ^ d; end
        1: begin c = 8'h02; cs = c ^ a; end
        2: begin c = 8'h01; cs = c ^ a ^ d ^ 8'($urandom_range(1, 255)); end
        default: begin
          c = 8'($urandom_range(0, 255));
          while (c == 8'h01 || c == 8'h02) c = 8'($urandom_range(0, 255));
          cs = 8'($urandom_range(0, 255));
        end
      endcase
      runPacket(c, a, d, cs, rv, $urandom_range(0, 2), 1'b0, 3, $sformatf("rnd%0d", i));
    end

    $display("[TB] overrun during response");
    runPacket(8'h01, 8'h44, 8'h99, 8'h01 ^ 8'h44 ^ 8'h99, 8'h5A, 0, 1'b1, 1, "overrun");

    $display("[TB] error counter saturation");
    for (int i = 0; i < 260; i++) begin
      runPacket(8'h01, 8'h10, 8'h3C, 8'h00, 8'h5A, 0, 1'b0, 0, "sat");
    end
    checkOutput("sat.final", int'(err_count), 255);

    $display("[TB] reset mid-packet");
    clearQueues();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h10, 0);
    rst_n = 1'b0;
    #1;
    errExp = 0;
    checkOutput("midRst.strobes", int'({reg_wr_en, reg_rd_en, tx_start, busy}), 0);
    checkOutput("midRst.regAddr", int'(reg_addr), 0);
    checkOutput("midRst.errCount", int'(err_count), 0);
    checkOutput("midRst.txData", int'(tx_data), 0);
    repeat (2) waitCycle();
    rst_n = 1'b1;
    repeat (TIMEOUT + 10) waitCycle();
    checkOutput("midRst.noWrite", wrAddrQ.size(), 0);
    checkOutput("midRst.noTx", txQ.size(), 0);
    checkOutput("midRst.busy", int'(busy), 0);
    checkOutput("midRst.errAfter", int'(err_count), 0);
    runPacket(8'h02, 8'h7E, 8'h00, 8'h02 ^ 8'h7E, 8'hC3, 0, 1'b0, 2, "afterRst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
